// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops words through a 1-cycle-latency read port,
// packs PACK words per beat onto a valid/ready stream, and emits partial beats on flush.
module fifo_rd_packer #(
    parameter int DATA_WIDTH  = 8,
    parameter int PACK        = 4,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                         PresetFull,
    input  logic                         RClk,
    output logic                         fifo_rd_en,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    input  logic                         flush_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH*PACK-1:0]   out_data,
    output logic [COUNT_WIDTH-1:0]       out_count,
    output logic                         out_last,
    output logic                         busy
);
    localparam logic [COUNT_WIDTH-1:0] PACK_C = COUNT_WIDTH'(PACK);

    logic [DATA_WIDTH-1:0]      skid0, skid1, skid0_n, skid1_n, head;
    logic [1:0]                 skid_cnt, skid_cnt_n;
    logic                       inflight, flush_pending, flush_pending_n;
    logic [COUNT_WIDTH-1:0]     lane_cnt, lane_n, count_n;
    logic [DATA_WIDTH*PACK-1:0] data_n;
    logic                       valid_n, last_n;
    logic                       room, have_word, handshake, can_take, take;
    logic                       pop_skid, push_skid, flush_go;

    // At most two words may be outstanding (skid + in flight), so the skid never overflows.
    assign room       = (skid_cnt == 2'd0) || (skid_cnt == 2'd1 && !inflight);
    assign fifo_rd_en = !PresetFull && !fifo_empty && room;

    assign have_word = (skid_cnt != 2'd0) || inflight;
    assign head      = (skid_cnt != 2'd0) ? skid0 : fifo_data;
    assign handshake = out_valid && out_ready;
    assign can_take  = (!out_valid && (lane_cnt < PACK_C)) || handshake;
    assign take      = have_word && can_take;
    assign flush_go  = flush_pending && !out_valid && (skid_cnt == 2'd0) && !inflight && fifo_empty;

    assign pop_skid  = take && (skid_cnt != 2'd0);
    assign push_skid = inflight && ((skid_cnt != 2'd0) || !take);

    assign busy = (skid_cnt != 2'd0) || inflight || (lane_cnt != '0) || out_valid;

    // A pulse arriving in the cycle the flush executes is absorbed by that flush.
    assign flush_pending_n = flush_go ? 1'b0 : (flush_pending || flush_in);

    always_comb begin
        skid0_n    = skid0;
        skid1_n    = skid1;
        skid_cnt_n = skid_cnt;
        if (pop_skid) begin
            skid0_n    = skid1;
            skid_cnt_n = skid_cnt - 1'b1;
        end
        if (push_skid) begin
            if (skid_cnt_n == 2'd0) skid0_n = fifo_data;
            else                    skid1_n = fifo_data;
            skid_cnt_n = skid_cnt_n + 1'b1;
        end
    end

    always_comb begin
        data_n  = out_data;
        lane_n  = lane_cnt;
        valid_n = out_valid;
        count_n = out_count;
        last_n  = out_last;
        // A handshake retires the beat and clears the lanes so partial beats stay zero-padded.
        if (handshake) begin
            data_n  = '0;
            lane_n  = '0;
            valid_n = 1'b0;
            count_n = '0;
            last_n  = 1'b0;
        end
        if (take) begin
            for (int i = 0; i < PACK; i++)
                if (COUNT_WIDTH'(i) == lane_n) data_n[i*DATA_WIDTH +: DATA_WIDTH] = head;
            lane_n = lane_n + 1'b1;
            if (lane_n == PACK_C) begin
                valid_n = 1'b1;
                count_n = PACK_C;
                last_n  = 1'b0;
            end
        end
        if (flush_go && (lane_cnt != '0)) begin
            valid_n = 1'b1;
            count_n = lane_cnt;
            last_n  = 1'b1;
            lane_n  = '0;
        end
    end

    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            skid0         <= '0;
            skid1         <= '0;
            skid_cnt      <= '0;
            inflight      <= 1'b0;
            flush_pending <= 1'b0;
            lane_cnt      <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_count     <= '0;
            out_last      <= 1'b0;
        end else begin
            skid0         <= skid0_n;
            skid1         <= skid1_n;
            skid_cnt      <= skid_cnt_n;
            inflight      <= fifo_rd_en && !fifo_empty;
            flush_pending <= flush_pending_n;
            lane_cnt      <= lane_n;
            out_data      <= data_n;
            out_valid     <= valid_n;
            out_count     <= count_n;
            out_last      <= last_n;
        end
    end
endmodule
